// File: rtl/fpu_clock_gate_ctrl.sv
// Per-unit clock-gate controller for the shared FPU interconnect: tracks pending
// operations per unit and keeps each unit's clock on for a hold-off window after it drains.
module fpu_clock_gate_ctrl #(
    parameter int NB_UNITS      = 4,
    parameter int CNT_WIDTH     = 3,
    parameter int HOLDOFF_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     auto_cg_en_i,
    input  logic [HOLDOFF_WIDTH-1:0] holdoff_cycles_i,
    input  logic                     clear_err_i,
    input  logic [NB_UNITS-1:0]      req_i,
    input  logic [NB_UNITS-1:0]      gnt_i,
    input  logic [NB_UNITS-1:0]      rvalid_i,
    output logic [NB_UNITS-1:0]      cg_en_o,
    output logic [NB_UNITS-1:0]      busy_o,
    output logic [NB_UNITS-1:0]      ovf_o,
    output logic [NB_UNITS-1:0]      unf_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
    localparam logic [HOLDOFF_WIDTH-1:0] TMR_ONE = HOLDOFF_WIDTH'(1);

    logic [NB_UNITS-1:0] ovf_set;
    logic [NB_UNITS-1:0] unf_set;

    for (genvar i = 0; i < NB_UNITS; i++) begin : g_unit
        logic                     acc;
        logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
        logic [HOLDOFF_WIDTH-1:0] tmr_q, tmr_d;
        state_t                   state_q, state_d;

        assign acc = req_i[i] & gnt_i[i];

        // Pending counter saturates at both ends; the blocked step is reported as an error.
        always_comb begin
            cnt_d      = cnt_q;
            ovf_set[i] = 1'b0;
            unf_set[i] = 1'b0;
            if (acc && !rvalid_i[i]) begin
                if (cnt_q == CNT_MAX) ovf_set[i] = 1'b1;
                else                  cnt_d = cnt_q + 1'b1;
            end else if (!acc && rvalid_i[i]) begin
                if (cnt_q == '0) unf_set[i] = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
        end

        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            case (state_q)
                IDLE: begin
                    if (acc || cnt_q != '0) state_d = ACTIVE;
                end
                ACTIVE: begin
                    if (cnt_q == '0 && !req_i[i]) begin
                        if (holdoff_cycles_i == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DRAIN;
                            tmr_d   = holdoff_cycles_i;
                        end
                    end
                end
                DRAIN: begin
                    if (req_i[i] || cnt_q != '0) state_d = ACTIVE;
                    else if (tmr_q <= TMR_ONE)   state_d = IDLE;
                    else                         tmr_d = tmr_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q   <= '0;
                tmr_q   <= '0;
                state_q <= IDLE;
            end else begin
                cnt_q   <= cnt_d;
                tmr_q   <= tmr_d;
                state_q <= state_d;
            end
        end

        assign busy_o[i]  = (state_q != IDLE);
        // Request opens the gate combinationally so the unit is clocked before its grant.
        assign cg_en_o[i] = ~auto_cg_en_i | req_i[i] | busy_o[i];
    end

    // A fresh error event in the clearing cycle takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o <= '0;
            unf_o <= '0;
        end else begin
            ovf_o <= (ovf_o & {NB_UNITS{~clear_err_i}}) | ovf_set;
            unf_o <= (unf_o & {NB_UNITS{~clear_err_i}}) | unf_set;
        end
    end

endmodule

// File: tb/tb_fpu_clock_gate_ctrl.sv
// Directed bench for fpu_clock_gate_ctrl: per-cycle expected outputs are queued by the driver
// and checked by an independent negedge monitor.
module tb_fpu_clock_gate_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          auto_cg_en;
    logic [3:0]    holdoff_cycles;
    logic          clear_err;
    logic [NB-1:0] req, gnt, rvalid;
    logic [NB-1:0] cg_en, busy, ovf, unf;

    logic          cfg_rst_n;
    logic          cfg_auto;
    logic [3:0]    cfg_hold;

    logic [15:0]   exp_q[$];
    string         name_q[$];
    int            checks = 0;
    int            errors = 0;

    fpu_clock_gate_ctrl #(
        .NB_UNITS(NB),
        .CNT_WIDTH(2),
        .HOLDOFF_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .auto_cg_en_i(auto_cg_en),
        .holdoff_cycles_i(holdoff_cycles),
        .clear_err_i(clear_err),
        .req_i(req),
        .gnt_i(gnt),
        .rvalid_i(rvalid),
        .cg_en_o(cg_en),
        .busy_o(busy),
        .ovf_o(ovf),
        .unf_o(unf)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver: one call = one cycle of inputs plus the outputs expected in that cycle
    task automatic cyc(input logic [3:0] rq, input logic [3:0] gn, input logic [3:0] rv,
                       input logic clr, input logic [3:0] e_cg, input logic [3:0] e_busy,
                       input logic [3:0] e_ovf, input logic [3:0] e_unf, input string nm);
        @(posedge clk);
        #1;
        rst_n          = cfg_rst_n;
        auto_cg_en     = cfg_auto;
        holdoff_cycles = cfg_hold;
        req            = rq;
        gnt            = gn;
        rvalid         = rv;
        clear_err      = clr;
        exp_q.push_back({e_cg, e_busy, e_ovf, e_unf});
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            logic [15:0] got;
            string       nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {cg_en, busy, ovf, unf};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s @%0t: got cg=%b busy=%b ovf=%b unf=%b, expected cg=%b busy=%b ovf=%b unf=%b",
                         nm, $time, got[15:12], got[11:8], got[7:4], got[3:0],
                         e[15:12], e[11:8], e[7:4], e[3:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b1; auto_cg_en = 1'b1; holdoff_cycles = '0; clear_err = 1'b0;
        req = '0; gnt = '0; rvalid = '0;
        cfg_rst_n = 1'b0; cfg_auto = 1'b1; cfg_hold = 4'd3;
        #2 rst_n = 1'b0;

        // reset: enable follows req when auto, all-ones otherwise
        cyc(4'b0101, 4'b0101, 4'b0000, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, "rst_req");
        cfg_auto = 1'b0;
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "rst_override");
        cfg_auto = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "rst_idle");
        cfg_rst_n = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "post_rst_idle");

        // single op, H=3, unit 0: rvalid at c4, enable falls at c9
        cyc(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "single_c0");
        for (int k = 1; k <= 3; k++)
            cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "single_active");
        cyc(4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "single_rvalid");
        for (int k = 5; k <= 8; k++)
            cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "single_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "single_fall_c9");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "single_idle");

        // H=0, unit 1: last rvalid at c1, enable falls at c3
        cfg_hold = 4'd0;
        cyc(4'b0010, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, "h0_acc");
        cyc(4'b0000, 4'b0000, 4'b0010, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "h0_rvalid");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "h0_last_on");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "h0_fall");

        // burst with hysteresis, H=2, unit 3: req during DRAIN, then H changed mid-drain
        cfg_hold = 4'd2;
        cyc(4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, "burst_acc0");
        cyc(4'b1000, 4'b1000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_acc1");
        cyc(4'b0000, 4'b0000, 4'b1000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_rv0");
        cyc(4'b0000, 4'b0000, 4'b1000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_rv1");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_to_drain");
        cyc(4'b1000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_req_in_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_redrain");
        cfg_hold = 4'd7;
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_drain_t2");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1000, 4'b1000, 4'b0000, 4'b0000, "burst_drain_t1");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "burst_fall");

        // saturation (2-bit counter), H=0, unit 0; then clear, and set-wins-over-clear
        cfg_hold = 4'd0;
        cyc(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "sat_acc1");
        cyc(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "sat_acc2");
        cyc(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "sat_acc3");
        cyc(4'b0001, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "sat_acc4_at_max");
        cyc(4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "sat_ovf_rv1");
        cyc(4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "sat_rv2");
        cyc(4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "sat_rv3");
        cyc(4'b0000, 4'b0000, 4'b0001, 0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, "sat_rv4_at_zero");
        cyc(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0001, "sat_unf_clear");
        cyc(4'b0000, 4'b0000, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "sat_cleared");
        cyc(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, "sat_set_wins");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "sat_clear2");

        // simultaneous acc & rvalid on unit 1 at p=1, then at p=0
        cyc(4'b0010, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, "sim1_acc");
        for (int k = 0; k < 8; k++)
            cyc(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "sim1_both");
        cyc(4'b0000, 4'b0000, 4'b0010, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "sim1_rv");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "sim1_last_on");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "sim1_fall");
        cyc(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, "sim0_first");
        for (int k = 1; k < 8; k++)
            cyc(4'b0010, 4'b0010, 4'b0010, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "sim0_both");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, "sim0_last_on");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "sim0_fall_no_unf");

        // override with 2 ops in flight on unit 2, H=1; re-enable before responses
        cfg_hold = 4'd1;
        cfg_auto = 1'b0;
        cyc(4'b0100, 4'b0100, 4'b0000, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, "ovr_acc0");
        cyc(4'b0100, 4'b0100, 4'b0000, 0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, "ovr_acc1");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b1111, 4'b0100, 4'b0000, 4'b0000, "ovr_forced");
        cfg_auto = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ovr_reenable");
        cyc(4'b0000, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ovr_rv0");
        cyc(4'b0000, 4'b0000, 4'b0100, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ovr_rv1");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ovr_to_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ovr_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "ovr_fall");

        // unit-2-only traffic, then async reset mid-burst; late response sets unf
        cfg_hold = 4'd3;
        cyc(4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "ind_acc0");
        cyc(4'b0100, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ind_acc1");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "ind_busy");
        cfg_rst_n = 1'b0;
        cyc(4'b0101, 4'b0100, 4'b0000, 0, 4'b0101, 4'b0000, 4'b0000, 4'b0000, "mid_rst_req");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mid_rst_idle");
        cfg_rst_n = 1'b1;
        cyc(4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "late_rv");
        cyc(4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, "late_unf");
        cyc(4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "late_cleared");

        // bounded wait for the monitor to consume everything
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d expected entries left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_clock_gate_ctrl.md
# fpu_clock_gate_ctrl

Parametrised per-unit clock-gate controller for the shared FPU interconnect. It drives the clock-gate enables of NB_UNITS FP units and tracks outstanding operations per unit with saturating counters. Each unit's clock stays enabled for a programmable hold-off window after its last response, so that back-to-back bursts do not toggle the gate every cycle. Counter overflow and underflow are flagged as sticky errors.

## Interface
- NB_UNITS, 4: number of gated FP units (channels), ≥1
- CNT_WIDTH, 3: width of each pending-operation counter, ≥1
- HOLDOFF_WIDTH, 4: width of the hold-off timer and of holdoff_cycles_i, ≥1

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- auto_cg_en_i  in  1  1 = automatic gating active; 0 = all enables forced to 1
- holdoff_cycles_i  in  HOLDOFF_WIDTH  idle cycles to keep a unit's clock enabled after it drains (H)
- clear_err_i  in  1  synchronous clear of both sticky error vectors
- req_i  in  NB_UNITS  per-unit request from the interconnect
- gnt_i  in  NB_UNITS  per-unit grant from the unit
- rvalid_i  in  NB_UNITS  per-unit response valid from the unit
- cg_en_o  out  NB_UNITS  per-unit clock-gate enable (combinational)
- busy_o  out  NB_UNITS  per-unit FSM state is not IDLE (registered)
- ovf_o  out  NB_UNITS  sticky: increment attempted at counter max
- unf_o  out  NB_UNITS  sticky: decrement attempted at counter zero

## Operation
- Per-unit pending counter p, CNT_WIDTH bits:
  - acc = req_i & gnt_i.
  - acc & ~rvalid: if p is at max, hold and set ovf; otherwise p+1.
  - ~acc & rvalid: if p is 0, hold and set unf; otherwise p-1.
  - acc & rvalid, or neither: hold.
  - p never wraps.
- Per-unit FSM, states IDLE, ACTIVE, DRAIN, with a hold-off timer T:
  - IDLE: if acc or p≠0, go to ACTIVE.
  - ACTIVE: if p==0 and ~req_i, go to DRAIN with T←holdoff_cycles_i, or straight to IDLE when holdoff_cycles_i==0. Otherwise stay.
  - DRAIN: if req_i or p≠0, go to ACTIVE. Else if T==1, go to IDLE. Else T←T-1.
  - holdoff_cycles_i is sampled only on the ACTIVE→DRAIN transition. Changing it mid-DRAIN has no effect.
- cg_en_o[i]:
  - auto_cg_en_i=0: 1.
  - auto_cg_en_i=1: req_i[i] | (state≠IDLE).
  - A request raised while IDLE enables the clock in the same cycle, before the grant.
- Counters and FSMs keep tracking while auto_cg_en_i=0, so re-enabling never gates a unit with work in flight.
- clear_err_i zeroes ovf_o/unf_o. If a new error event occurs in the same cycle, the set wins.
- Units are fully independent. No cross-channel interaction.

## Timing
- Reset values: p=0, T=0, all FSMs IDLE, busy_o=0, ovf_o=0, unf_o=0.
- During reset, cg_en_o equals req_i when auto_cg_en_i=1, and all-ones otherwise.
- Enable rise: combinational from req_i, 0-cycle latency.
- Enable fall, with the last rvalid in cycle t (p reads 0 in t+1):
  - cg_en_o stays 1 through cycle t+1+H.
  - cg_en_o falls in t+2+H.
  - With H=0 it falls in t+2.
- A req_i anywhere in DRAIN cancels the fall with no gap in the enable.
- busy_o follows the registered state: it rises the cycle after the first acc and falls together with the registered return to IDLE.
- Simultaneous acc and rvalid at p==0: p holds 0, no unf, FSM stays or goes ACTIVE.
- Async reset mid-operation: all state clears immediately. Outstanding responses arriving afterwards set unf_o; this is expected.

## Test plan
- Single op, H=3, unit 0: req+gnt at cycle 0, rvalid at cycle 4 → cg_en_o[0]=1 for cycles 0..8, 0 at cycle 9; p peaks at 1; no errors.
- Burst with hysteresis, H=2: ops complete at cycle 10; new req at cycle 12 (in DRAIN) → cg_en_o stays 1 continuously, FSM DRAIN→ACTIVE, T reloads on the next drain.
- Saturation, CNT_WIDTH=2: 4 accepted reqs with no rvalid → p=3, ovf_o[i]=1 on the 4th; then 4 rvalids → p=0 and unf_o[i]=1 on the 4th; clear_err_i → both 0.
- Simultaneous events: acc & rvalid every cycle for 8 cycles at p=1 → p stays 1, cg_en_o=1 throughout; the same at p=0 → p stays 0, no unf.
- Override: auto_cg_en_i=0 with 2 ops in flight → cg_en_o=all-ones; re-enable before the responses → that unit's enable stays 1 until drain+H; idle units drop immediately.
- Independence and reset, NB_UNITS=4: traffic only on unit 2 → cg_en_o=4'b0100 pattern; rst_n pulsed mid-burst → busy_o=0 and p=0 at once, and cg_en_o tracks req_i only.
